// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
// Shared definitions for the multicycle signed divider:
//   - DIV_WIDTH : default operand/result width
//   - MAX_W     : widest operand the helper functions accept
//   - div_state_t : divider FSM state encoding
//   - neg_w / abs_w : two's-complement helpers. Callers zero-extend their
//     operand to MAX_W and keep the low WIDTH bits of the result. Those bits
//     are exact modulo 2^WIDTH, so the helpers serve any WIDTH <= MAX_W.
// -----------------------------------------------------------------------------
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int MAX_W     = 64;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_FIX  = 3'd2,
        S_DONE = 3'd3,
        S_ZERR = 3'd4
    } div_state_t;

    // Two's-complement negation (modulo 2^MAX_W).
    function automatic logic [MAX_W-1:0] neg_w(input logic [MAX_W-1:0] v);
        return ~v + MAX_W'(1);
    endfunction

    // Magnitude of a value whose sign bit is supplied separately. The most
    // negative value maps to itself, which is correct modulo 2^WIDTH.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v,
                                               input logic             is_neg);
        return is_neg ? neg_w(v) : v;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multicycle signed restoring divider (MIPS DIV semantics: the quotient
// truncates toward zero and the remainder takes the sign of the dividend).
// One quotient bit is produced per clock, so the cost is one subtractor, a
// remainder/quotient shift-register pair and an iteration counter.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   div_init  in   start request, accepted only when idle
//   dividend  in   signed dividend, sampled with div_init
//   divisor   in   signed divisor, sampled with div_init
//   div_stop  out  one-cycle done pulse, hi/lo valid while high
//   div_zero  out  one-cycle divide-by-zero pulse
//   busy      out  operation in progress
//   hi        out  remainder, held until the next successful division
//   lo        out  quotient, held until the next successful division
// WIDTH must be between 2 and MAX_W.
// -----------------------------------------------------------------------------
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_init,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             div_stop,
    output logic             div_zero,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       r_state;
    logic [WIDTH-1:0] r_q;      // quotient shift register (holds |dividend| at start)
    logic [WIDTH-1:0] r_rem;    // partial remainder
    logic [WIDTH-1:0] r_dvs;    // |divisor|
    logic             r_sq;     // quotient is negative
    logic             r_sr;     // remainder is negative
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_stop;
    logic             r_zero;
    logic             r_busy;

    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_lo_fix;
    logic [WIDTH-1:0] w_hi_fix;

    assign w_dvd_abs = WIDTH'(abs_w(MAX_W'(dividend), dividend[WIDTH-1]));
    assign w_dvs_abs = WIDTH'(abs_w(MAX_W'(divisor),  divisor[WIDTH-1]));

    // Shifted remainder {rem, q_msb} minus |divisor|. The remainder is always
    // below |divisor| <= 2^(WIDTH-1), so the shifted value stays below 2^WIDTH
    // and the top bit of this WIDTH+1 bit difference is a clean borrow.
    assign w_trial = {r_rem, r_q[WIDTH-1]} - {1'b0, r_dvs};

    assign w_lo_fix = r_sq ? WIDTH'(neg_w(MAX_W'(r_q)))   : r_q;
    assign w_hi_fix = r_sr ? WIDTH'(neg_w(MAX_W'(r_rem))) : r_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_sq    <= 1'b0;
            r_sr    <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_stop  <= 1'b0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_stop <= 1'b0;
                    r_busy <= div_init;
                    if (div_init) begin
                        if (divisor == '0) begin
                            r_zero  <= 1'b1;
                            r_state <= S_ZERR;
                        end else begin
                            r_q     <= w_dvd_abs;
                            r_dvs   <= w_dvs_abs;
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_sq    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_sr    <= dividend[WIDTH-1];
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                    end else begin
                        r_rem <= {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
                    end
                    r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_lo    <= w_lo_fix;
                    r_hi    <= w_hi_fix;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // busy stays up through the div_stop cycle and drops
                    // once the FSM is back in IDLE.
                    r_stop  <= 1'b1;
                    r_state <= S_IDLE;
                end
                S_ZERR: begin
                    r_zero  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign div_stop = r_stop;
    assign div_zero = r_zero;
    assign busy     = r_busy;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        div_init = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        div_stop;
    logic        div_zero;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .div_init (div_init),
        .dividend (dividend),
        .divisor  (divisor),
        .div_stop (div_stop),
        .div_zero (div_zero),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands with div_init, let edge N sample them, then drop div_init.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        div_init = 1'b1;
        @(posedge clk);
        #1;
        div_init = 1'b0;
    endtask

    // Starts a division and follows it for 35 edges. If poke_at > 0, a second
    // start request with operands pa/pb is held across edge poke_at+1 while
    // the divider is still running and must have no effect.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input int poke_at, input logic [31:0] pa, input logic [31:0] pb);
        start(a, b);
        chk({tag, ":busy_start"}, {31'b0, busy}, 32'd1);
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk);
            #1;
            if (k == poke_at) begin
                dividend = pa;
                divisor  = pb;
                div_init = 1'b1;
            end
            if (k == poke_at + 1) div_init = 1'b0;
            if (k == 33) chk({tag, ":stop_early"}, {31'b0, div_stop}, 32'd0);
            if (k == 34) begin
                chk({tag, ":stop"}, {31'b0, div_stop}, 32'd1);
                chk({tag, ":busy_at_stop"}, {31'b0, busy}, 32'd1);
                chk({tag, ":lo"}, lo, exp_lo);
                chk({tag, ":hi"}, hi, exp_hi);
            end
            if (k == 35) begin
                chk({tag, ":stop_fall"}, {31'b0, div_stop}, 32'd0);
                chk({tag, ":busy_fall"}, {31'b0, busy}, 32'd0);
                chk({tag, ":lo_hold"}, lo, exp_lo);
            end
        end
        $display("txn %s: %h / %h -> lo=%h hi=%h (expect lo=%h hi=%h)",
                 tag, a, b, lo, hi, exp_lo, exp_hi);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst:lo", lo, 32'd0);
        chk("rst:hi", hi, 32'd0);
        chk("rst:busy", {31'b0, busy}, 32'd0);
        chk("rst:stop", {31'b0, div_stop}, 32'd0);
        chk("rst:zero", {31'b0, div_zero}, 32'd0);
        reset = 1'b0;
        $display("txn reset: lo=%h hi=%h busy=%b", lo, hi, busy);

        // Basic signs
        run_div("7/2",  32'd7,        32'd2,        32'd3,        32'd1,        0, '0, '0);
        run_div("-7/2", 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 0, '0, '0);
        run_div("7/-2", 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        0, '0, '0);

        // Prime lo=5, hi=9, then divide by zero: results must not move
        run_div("59/10", 32'd59, 32'd10, 32'd5, 32'd9, 0, '0, '0);
        start(32'd123, 32'd0);
        chk("dz:zero", {31'b0, div_zero}, 32'd1);
        chk("dz:busy", {31'b0, busy}, 32'd1);
        chk("dz:stop", {31'b0, div_stop}, 32'd0);
        @(posedge clk);
        #1;
        chk("dz:zero_fall", {31'b0, div_zero}, 32'd0);
        chk("dz:busy_fall", {31'b0, busy}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("dz:no_stop", {31'b0, div_stop}, 32'd0);
        end
        chk("dz:lo_held", lo, 32'd5);
        chk("dz:hi_held", hi, 32'd9);
        $display("txn 123/0: zero flagged, lo=%h hi=%h kept", lo, hi);

        // Boundary cases
        run_div("min/-1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, '0, '0);
        run_div("3/10",   32'd3,        32'd10,       32'd0,        32'd3, 0, '0, '0);
        run_div("0/5",    32'd0,        32'd5,        32'd0,        32'd0, 0, '0, '0);
        run_div("-3/10",  32'hFFFFFFFD, 32'd10,       32'd0,        32'hFFFFFFFD, 0, '0, '0);

        // Start request during RUN (iteration 10) is ignored
        run_div("1000/3+poke", 32'd1000, 32'd3, 32'd333, 32'd1, 10, 32'd7, 32'd2);

        // Reset mid-operation, then a start in the first cycle after reset
        start(32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mrst:lo", lo, 32'd0);
        chk("mrst:hi", hi, 32'd0);
        chk("mrst:busy", {31'b0, busy}, 32'd0);
        chk("mrst:stop", {31'b0, div_stop}, 32'd0);
        chk("mrst:zero", {31'b0, div_zero}, 32'd0);
        $display("txn mid-run reset: lo=%h hi=%h busy=%b", lo, hi, busy);
        reset = 1'b0;
        run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
